led_scan_ctrl: RTL and testbench
================================

Name: led_scan_ctrl

Overview:
Sequencer and arbiter for the 8x8x4-bit LED display RAM. It row-scans the RAM to drive the LED matrix (one-hot row select plus red/green column lines). It shares the RAM's single address port with the light-pen write path through a valid/ready handshake. It sits between the pen/touch logic, the LED RAM and the matrix pins.

Parameters:
ROWS, 8, matrix rows; row_sel width.
COLS, 8, matrix columns; col_r/col_g width.
DWELL_CYCLES, 1000, clock cycles each row stays lit (minimum 2).
ADDR_W, 8, RAM row/column address width.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
wr_valid  in  1  pen write request
wr_ready  out  1  controller accepts the write this cycle
wr_row  in  ADDR_W  write row address
wr_col  in  ADDR_W  write column address
wr_data  in  4  LED word: [3] stored, [2] G, [1] R, [0] reserved
wr_err  out  1  one-cycle pulse: accepted write was out of range
ram_addr_row  out  ADDR_W  RAM row address
ram_addr_col  out  ADDR_W  RAM column address
ram_data  out  4  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  4  RAM read data, valid one cycle after its address
row_sel  out  ROWS  one-hot active-high row drive
col_r  out  COLS  red column drive, active-high
col_g  out  COLS  green column drive, active-high
frame_start  out  1  one-cycle pulse when the row-0 load begins

Behaviour:
- Reset (asynchronous, any time, including mid-load or mid-write): state=LOAD, row=0, col=0, dwell=0.
  - Outputs: row_sel=0, col_r=0, col_g=0, wr_ready=0, ram_we=0, wr_err=0, frame_start=0.
  - Column buffer cleared.
  - First cycle after release: frame_start=1 and the row-0 load starts.
- FSM states: LOAD, SHOW.
- LOAD (COLS+1 cycles):
  - Cycle k (0..COLS-1): drive ram_addr_row=row, ram_addr_col=k, ram_we=0.
  - Cycles 1..COLS: capture ram_rdata into buf[k-1].
  - row_sel=0 throughout (blanking) and wr_ready=0.
  - After the last capture: go to SHOW and load display registers.
- Display registers, loaded on LOAD->SHOW:
  - row_sel = 1<<row.
  - col_r[c] = buf[c][3] & buf[c][1].
  - col_g[c] = buf[c][3] & buf[c][2].
  - If buf[c][3]=0, the column is off regardless of [2:1].
- SHOW (DWELL_CYCLES cycles):
  - Outputs held.
  - wr_ready=1 every SHOW cycle, including the last.
  - On wr_valid&wr_ready: ram_addr_row/col=wr_row/wr_col, ram_data=wr_data, ram_we=1 in the same cycle (combinational mux).
- Out-of-range write (wr_row>=ROWS or wr_col>=COLS): handshake completes, ram_we=0, wr_err=1 on the next cycle.
- End of SHOW: row increments; row==ROWS-1 wraps to 0, and frame_start pulses on the first LOAD cycle of row 0. Then LOAD.
- Frame period: ROWS*(COLS+1+DWELL_CYCLES) cycles.
- Write to the currently lit row: the display is unchanged until that row's next LOAD. A write in the last SHOW cycle is visible to the immediately following LOAD.
- wr_valid during LOAD: the requester must hold wr_valid and its payload until wr_ready. The request is never dropped.
- Dwell counter width: $clog2(DWELL_CYCLES). Row/column counters are $clog2 of ROWS/COLS; the unused upper address bits are driven 0.

Optional Feature:
Macro LED_SCAN_TEST_EN.
- Defined: adds input test_mode (1 bit). When test_mode=1, col_r/col_g are loaded from an internal checkerboard instead of buf: col_r[c]=(row+c)%2==0, col_g[c]=(row+c)%2==1. RAM loading and write arbitration are unchanged.
- Undefined: no port and no logic.

Decomposition:
Shared package led_pkg:
- LED word bit indices: LED_STORED=3, LED_G=2, LED_R=1.
- State enum {LOAD, SHOW}.
- Default ROWS/COLS constants.
One natural sub-module, led_dwell_timer: a loadable down-counter with a done pulse, used for SHOW timing.

Test Plan:
- Reset, then idle with RAM all 0 and DWELL_CYCLES=4 -> frame_start every 104 cycles; row_sel sequences 0x01..0x80; col_r=col_g=0.
- RAM[2][5]=4'b1010 -> when row_sel=0x04, col_r=0x20 and col_g=0x00.
- RAM[3][0]=4'b0110 (stored bit clear) -> row 3 shows col_r=col_g=0.
- wr_valid held from the first LOAD cycle with row=1, col=7, data=4'b1100 -> wr_ready rises at the first SHOW cycle; ram_we for exactly one cycle; the next row-1 SHOW has col_g=0x80.
- Write row=8, col=0 -> handshake completes, ram_we stays 0, wr_err pulses once.
- Assert rst mid-LOAD of row 5 -> all outputs 0 immediately; after release, frame_start=1 in the first cycle and the scan restarts at row 0.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared constants and types for the LED scan controller slice.
package led_pkg;

    // Bit positions inside a 4-bit LED RAM word.
    localparam int unsigned LED_STORED = 3;
    localparam int unsigned LED_G      = 2;
    localparam int unsigned LED_R      = 1;

    // Default matrix geometry.
    localparam int unsigned LED_ROWS_DEF = 8;
    localparam int unsigned LED_COLS_DEF = 8;

    typedef enum logic {
        LOAD,
        SHOW
    } led_state_e;

endpackage

// File: rtl/led_scan_ctrl_if.sv
// led_wr_if: light-pen write request channel (valid/ready) into the LED scan controller.
interface led_wr_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_row;
    logic [ADDR_W-1:0] wr_col;
    logic [3:0]        wr_data;
    logic              wr_err;

    modport master (
        output wr_valid, wr_row, wr_col, wr_data,
        input  wr_ready, wr_err
    );

    modport slave (
        input  wr_valid, wr_row, wr_col, wr_data,
        output wr_ready, wr_err
    );
endinterface

// File: rtl/led_dwell_timer.sv
// led_dwell_timer: loadable down-counter timing how long each row stays lit.
module led_dwell_timer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);
    logic [WIDTH-1:0] cnt_q;

    // Count down from the loaded value while enabled, parking at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    // Done marks the final enabled cycle.
    always_comb begin
        done = en && (cnt_q == '0);
    end
endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: row-scans the LED RAM onto the matrix pins and arbitrates the single
// RAM address port between scan reads and light-pen writes.
// Optional feature: define LED_SCAN_TEST_EN to add a test_mode checkerboard input.
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int unsigned ROWS         = LED_ROWS_DEF,
    parameter int unsigned COLS         = LED_COLS_DEF,
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef LED_SCAN_TEST_EN
    input  logic              test_mode,
`endif
    led_wr_if.slave           wr,
    output logic [ADDR_W-1:0] ram_addr_row,
    output logic [ADDR_W-1:0] ram_addr_col,
    output logic [3:0]        ram_data,
    output logic              ram_we,
    input  logic [3:0]        ram_rdata,
    output logic [ROWS-1:0]   row_sel,
    output logic [COLS-1:0]   col_r,
    output logic [COLS-1:0]   col_g,
    output logic              frame_start
);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned DW = $clog2(DWELL_CYCLES);

    led_state_e      state_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic            last_q;  // final LOAD cycle: capture only, no new address
    logic [3:0]      col_buf_q [COLS];
    logic [3:0]      col_buf_d [COLS];
    logic [ROWS-1:0] row_sel_q;
    logic [COLS-1:0] col_r_q;
    logic [COLS-1:0] col_g_q;
    logic [COLS-1:0] disp_r;
    logic [COLS-1:0] disp_g;
    logic            wr_err_q;
    logic            wr_ready;
    logic            wr_fire;
    logic            wr_in_range;
    logic            dwell_done;
    logic            unused_rsvd;

    led_dwell_timer #(
        .WIDTH (DW)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     ((state_q == LOAD) && last_q),
        .en       (state_q == SHOW),
        .load_val (DW'(DWELL_CYCLES - 1)),
        .done     (dwell_done)
    );

    // Write arbitration: pen owns the RAM port only on an accepted SHOW-phase handshake.
    always_comb begin
        wr_ready    = (state_q == SHOW);
        wr_fire     = wr.wr_valid && wr_ready;
        wr_in_range = (32'(wr.wr_row) < ROWS) && (32'(wr.wr_col) < COLS);
        ram_we      = wr_fire && wr_in_range;
        ram_data    = wr.wr_data;
        if (wr_fire) begin
            ram_addr_row = wr.wr_row;
            ram_addr_col = wr.wr_col;
        end else begin
            ram_addr_row = ADDR_W'(row_q);
            ram_addr_col = ADDR_W'(col_q);
        end
        wr.wr_ready  = wr_ready;
        wr.wr_err    = wr_err_q;
        row_sel      = row_sel_q;
        col_r        = col_r_q;
        col_g        = col_g_q;
        // Gated by rst so the pulse stays low while reset is held.
        frame_start  = !rst && (state_q == LOAD) && (row_q == '0) && (col_q == '0) && !last_q;
    end

    // Column buffer next-state: RAM data lands one cycle after its address was issued.
    always_comb begin
        col_buf_d = col_buf_q;
        if (state_q == LOAD) begin
            if (last_q) begin
                col_buf_d[COLS-1] = ram_rdata;
            end else if (col_q != '0) begin
                col_buf_d[col_q - CW'(1)] = ram_rdata;
            end
        end
    end

    // Display words for the row being loaded, including the capture of this cycle.
    always_comb begin
        disp_r      = '0;
        disp_g      = '0;
        unused_rsvd = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            disp_r[c]   = col_buf_d[c][LED_STORED] & col_buf_d[c][LED_R];
            disp_g[c]   = col_buf_d[c][LED_STORED] & col_buf_d[c][LED_G];
            unused_rsvd = unused_rsvd ^ col_buf_d[c][0];
`ifdef LED_SCAN_TEST_EN
            if (test_mode) begin
                disp_r[c] = ~(row_q[0] ^ c[0]);
                disp_g[c] = row_q[0] ^ c[0];
            end
`endif
        end
    end

    // Scan FSM: LOAD reads one row into the buffer, SHOW lights it for the dwell time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOAD;
            row_q     <= '0;
            col_q     <= '0;
            last_q    <= 1'b0;
            row_sel_q <= '0;
            col_r_q   <= '0;
            col_g_q   <= '0;
            wr_err_q  <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                col_buf_q[c] <= '0;
            end
        end else begin
            wr_err_q  <= wr_fire && !wr_in_range;
            col_buf_q <= col_buf_d;
            unique case (state_q)
                LOAD: begin
                    if (last_q) begin
                        last_q    <= 1'b0;
                        col_q     <= '0;
                        state_q   <= SHOW;
                        row_sel_q <= ROWS'(1) << row_q;
                        col_r_q   <= disp_r;
                        col_g_q   <= disp_g;
                    end else if (col_q == CW'(COLS - 1)) begin
                        last_q <= 1'b1;
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
                SHOW: begin
                    if (dwell_done) begin
                        state_q   <= LOAD;
                        col_q     <= '0;
                        row_sel_q <= '0;
                        col_r_q   <= '0;
                        col_g_q   <= '0;
                        row_q     <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: randomized pen writes against a cycle-count reference model of the scan.
module tb_led_scan_ctrl;
    localparam int unsigned ROWS   = 8;
    localparam int unsigned COLS   = 8;
    localparam int unsigned DWELL  = 4;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned SEG    = COLS + 1 + DWELL;
    localparam int unsigned PERIOD = ROWS * SEG;
    localparam int unsigned RB     = $clog2(ROWS);
    localparam int unsigned CB     = $clog2(COLS);

    typedef struct {
        int         at;
        logic [7:0] req_row;
        logic [7:0] req_col;
        logic [3:0] req_data;
    } req_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] ram_addr_row;
    logic [ADDR_W-1:0] ram_addr_col;
    logic [3:0]        ram_data;
    logic              ram_we;
    logic [3:0]        ram_rdata;
    logic [ROWS-1:0]   row_sel;
    logic [COLS-1:0]   col_r;
    logic [COLS-1:0]   col_g;
    logic              frame_start;

    logic [3:0] ram_mem   [ROWS][COLS];
    logic [3:0] init_mem  [ROWS][COLS];
    logic [3:0] model_mem [ROWS][COLS];
    logic [3:0] lit       [COLS];
    logic       ram_init;
    req_t       dq [$];
    int         t;
    int         n_checks;
    int         n_fail;
    bit         err_pend;
    bit         accepted;

    led_wr_if #(.ADDR_W(ADDR_W)) wr_bus ();

    led_scan_ctrl #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .DWELL_CYCLES (DWELL),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef LED_SCAN_TEST_EN
        .test_mode    (1'b0),
`endif
        .wr           (wr_bus),
        .ram_addr_row (ram_addr_row),
        .ram_addr_col (ram_addr_col),
        .ram_data     (ram_data),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata),
        .row_sel      (row_sel),
        .col_r        (col_r),
        .col_g        (col_g),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous LED RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_init) begin
            ram_mem <= init_mem;
        end else if (ram_we) begin
            ram_mem[ram_addr_row[RB-1:0]][ram_addr_col[CB-1:0]] <= ram_data;
        end
        ram_rdata <= ram_mem[ram_addr_row[RB-1:0]][ram_addr_col[CB-1:0]];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got 0x%0h expected 0x%0h", tag, t, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, ".row_sel"}, row_sel, 0);
        check_eq({tag, ".col_r"}, col_r, 0);
        check_eq({tag, ".col_g"}, col_g, 0);
        check_eq({tag, ".wr_ready"}, wr_bus.wr_ready, 0);
        check_eq({tag, ".ram_we"}, ram_we, 0);
        check_eq({tag, ".wr_err"}, wr_bus.wr_err, 0);
        check_eq({tag, ".frame_start"}, frame_start, 0);
        check_eq({tag, ".addr_row"}, ram_addr_row, 0);
        check_eq({tag, ".addr_col"}, ram_addr_col, 0);
    endtask

    // Each iteration starts at a falling edge: drive, settle, compare, advance the model.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            int              s;
            int              r;
            bit              showing;
            bit              fire;
            bit              in_rng;
            logic [COLS-1:0] er;
            logic [COLS-1:0] eg;
            req_t            req;

            s       = t % SEG;
            r       = (t / SEG) % ROWS;
            showing = (s >= COLS + 1);
            if (s == 0) begin
                for (int c = 0; c < COLS; c++) lit[c] = model_mem[r][c];
            end

            if (accepted) begin
                wr_bus.wr_valid = 1'b0;
                accepted        = 1'b0;
            end else if (!wr_bus.wr_valid) begin
                if (dq.size() != 0) begin
                    if (t >= dq[0].at) begin
                        req             = dq.pop_front();
                        wr_bus.wr_valid = 1'b1;
                        wr_bus.wr_row   = req.req_row;
                        wr_bus.wr_col   = req.req_col;
                        wr_bus.wr_data  = req.req_data;
                    end
                end else if ($urandom_range(3) == 0) begin
                    wr_bus.wr_valid = 1'b1;
                    wr_bus.wr_row   = 8'($urandom_range(ROWS));
                    wr_bus.wr_col   = 8'($urandom_range(COLS));
                    wr_bus.wr_data  = 4'($urandom);
                end
            end

            #1;
            in_rng = (wr_bus.wr_row < ROWS) && (wr_bus.wr_col < COLS);
            fire   = wr_bus.wr_valid && showing;
            er     = '0;
            eg     = '0;
            if (showing) begin
                for (int c = 0; c < COLS; c++) begin
                    // Stored flag gates both colours.
                    er[c] = lit[c][3] && lit[c][1];
                    eg[c] = lit[c][3] && lit[c][2];
                end
            end

            check_eq("row_sel", row_sel, showing ? (64'd1 << r) : 64'd0);
            check_eq("col_r", col_r, er);
            check_eq("col_g", col_g, eg);
            check_eq("wr_ready", wr_bus.wr_ready, showing);
            check_eq("frame_start", frame_start, (t % PERIOD) == 0);
            check_eq("wr_err", wr_bus.wr_err, err_pend);
            check_eq("ram_we", ram_we, fire && in_rng);
            if (fire) begin
                check_eq("wr_addr_row", ram_addr_row, wr_bus.wr_row);
                check_eq("wr_addr_col", ram_addr_col, wr_bus.wr_col);
                check_eq("wr_ram_data", ram_data, wr_bus.wr_data);
            end else if (!showing && s < COLS) begin
                check_eq("scan_addr_row", ram_addr_row, r);
                check_eq("scan_addr_col", ram_addr_col, s);
            end

            err_pend = fire && !in_rng;
            if (fire) begin
                if (in_rng) model_mem[wr_bus.wr_row][wr_bus.wr_col] = wr_bus.wr_data;
                accepted = 1'b1;
            end
            t++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        t               = 0;
        err_pend        = 1'b0;
        accepted        = 1'b0;
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_row   = '0;
        wr_bus.wr_col   = '0;
        wr_bus.wr_data  = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) model_mem[r][c] = 4'h0;
        end
        model_mem[2][5] = 4'b1010;
        model_mem[3][0] = 4'b0110;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) init_mem[r][c] = model_mem[r][c];
        end
        ram_init = 1'b1;

        // Held from the first LOAD cycle of row 1, then an out-of-range row.
        dq.push_back('{at: PERIOD + SEG, req_row: 8'd1, req_col: 8'd7, req_data: 4'b1100});
        dq.push_back('{at: PERIOD + 3 * SEG, req_row: 8'd8, req_col: 8'd0, req_data: 4'b1000});

        repeat (2) @(negedge clk);
        #1;
        check_reset("por");
        ram_init = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_cycles(3 * PERIOD + 5 * SEG + 3);

        // Now inside the LOAD of row 5.
        rst             = 1'b1;
        wr_bus.wr_valid = 1'b0;
        accepted        = 1'b0;
        err_pend        = 1'b0;
        #1;
        check_reset("mid_load");
        @(negedge clk);
        #1;
        check_reset("held");
        @(negedge clk);
        rst = 1'b0;
        t   = 0;
        run_cycles(5 * PERIOD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
